// File: rtl/shift_pkg.sv
// Shared types and elaboration-time helpers for the pipelined barrel shifter.
// The enum order fixes the op encoding: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    // Number of mux levels needed to cover a shift range of 'value' positions.
    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Levels owned by every stage except possibly the last one.
    function automatic int lvls_per_stage(input int levels, input int stages);
        return (levels + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/shift_if.sv
// Handshake bundle for the shifter: request side (in_*) and result side (out_*).
// The issue logic / testbench holds the master modport, the shifter the slave one.
interface shift_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) ();
    import shift_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    shift_op_e                in_op;
    logic [WIDTH-1:0]         in_a;
    logic [$clog2(WIDTH)-1:0] in_shamt;
    logic [TAG_W-1:0]         in_tag;

    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_result;
    logic [TAG_W-1:0]         out_tag;
    logic                     out_err;

    modport master (
        output in_valid, in_op, in_a, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_err
    );

endinterface

// File: rtl/shift_stage.sv
// Combinational slice of the right-shift core: mux levels LVL_LO..LVL_HI.
// Level i shifts right by 2^i when shamt[i] is set; vacated MSBs take 'fill'.
// With SHIFT_ROTATE_EN defined an extra 'rot' input recirculates the LSBs
// instead of filling. An empty range (LVL_HI < LVL_LO) is a plain wire.
module shift_stage #(
    parameter int WIDTH  = 64,
    parameter int LVL_LO = 0,
    parameter int LVL_HI = 0
) (
    input  logic [WIDTH-1:0]         din,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic                     fill,
`ifdef SHIFT_ROTATE_EN
    input  logic                     rot,
`endif
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] acc;

    // Walk this stage's levels in order, each one conditionally shifting by its power of two
    always_comb begin
        acc = din;
        for (int i = LVL_LO; i <= LVL_HI; i++) begin
            if (shamt[i]) begin
`ifdef SHIFT_ROTATE_EN
                if (rot) begin
                    acc = (acc >> (1 << i)) | (acc << (WIDTH - (1 << i)));
                end else begin
                    acc = (acc >> (1 << i)) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> (1 << i)));
                end
`else
                acc = (acc >> (1 << i)) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> (1 << i)));
`endif
            end
        end
        dout = acc;
    end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA, plus ROR when SHIFT_ROTATE_EN is defined).
// log2(WIDTH) right-shift mux levels are spread over STAGES register stages,
// LSB levels first. SLL reuses the right-shift core by bit-reversing the operand
// on entry and the result on exit. The whole pipe advances as one unit whenever
// the output register is empty or being consumed. Without SHIFT_ROTATE_EN, op 11
// runs as SRL and its result carries out_err=1.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input logic   clk,
    input logic   rst,
    shift_if.slave bus
);

    localparam int SHW  = log2_ceil(WIDTH);
    localparam int LVLS = SHW;
    localparam int PER  = lvls_per_stage(LVLS, STAGES);

    logic adv;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int  LO     = k * PER;
        localparam int  HI_RAW = (k + 1) * PER - 1;
        localparam int  HI     = (k == STAGES - 1) ? LVLS - 1 :
                                 ((HI_RAW > LVLS - 1) ? LVLS - 1 : HI_RAW);
        localparam bit  LAST   = (k == STAGES - 1);

        logic             src_valid;
        logic [WIDTH-1:0] src_value;
        logic [SHW-1:0]   src_shamt;
        shift_op_e        src_op;
        logic             src_fill;
        logic [TAG_W-1:0] src_tag;
        logic             src_err;

        logic [WIDTH-1:0] lvl_value;

        logic             valid_d, valid_q;
        logic [WIDTH-1:0] value_d, value_q;
        logic [SHW-1:0]   shamt_d, shamt_q;
        shift_op_e        op_d, op_q;
        logic             fill_d, fill_q;
        logic [TAG_W-1:0] tag_d, tag_q;
        logic             err_d, err_q;

        if (k == 0) begin : g_src
            // Entry stage: take the request from the bus, reverse left shifts, pick the fill bit
            always_comb begin
                src_valid = bus.in_valid;
                src_op    = bus.in_op;
                src_value = (bus.in_op == OP_SLL) ? bit_rev(bus.in_a) : bus.in_a;
                src_shamt = bus.in_shamt;
                src_fill  = (bus.in_op == OP_SRA) ? bus.in_a[WIDTH-1] : 1'b0;
                src_tag   = bus.in_tag;
`ifdef SHIFT_ROTATE_EN
                src_err   = 1'b0;
`else
                src_err   = (bus.in_op == OP_ROR);
`endif
            end
        end else begin : g_src
            // Later stages continue from the previous stage's register
            always_comb begin
                src_valid = g_stage[k-1].valid_q;
                src_op    = g_stage[k-1].op_q;
                src_value = g_stage[k-1].value_q;
                src_shamt = g_stage[k-1].shamt_q;
                src_fill  = g_stage[k-1].fill_q;
                src_tag   = g_stage[k-1].tag_q;
                src_err   = g_stage[k-1].err_q;
            end
        end

        shift_stage #(
            .WIDTH  (WIDTH),
            .LVL_LO (LO),
            .LVL_HI (HI)
        ) u_stage (
            .din   (src_value),
            .shamt (src_shamt),
            .fill  (src_fill),
`ifdef SHIFT_ROTATE_EN
            .rot   (src_op == OP_ROR),
`endif
            .dout  (lvl_value)
        );

        // Next register contents; the final stage undoes the SLL bit reversal
        always_comb begin
            valid_d = src_valid;
            value_d = lvl_value;
            if (LAST && (src_op == OP_SLL)) begin
                value_d = bit_rev(lvl_value);
            end
            shamt_d = src_shamt;
            op_d    = src_op;
            fill_d  = src_fill;
            tag_d   = src_tag;
            err_d   = src_err;
        end

        // Stage register: cleared on reset, frozen on stall, payload only loaded for real beats
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                value_q <= '0;
                shamt_q <= '0;
                op_q    <= OP_SLL;
                fill_q  <= 1'b0;
                tag_q   <= '0;
                err_q   <= 1'b0;
            end else if (adv) begin
                valid_q <= valid_d;
                if (valid_d) begin
                    value_q <= value_d;
                    shamt_q <= shamt_d;
                    op_q    <= op_d;
                    fill_q  <= fill_d;
                    tag_q   <= tag_d;
                    err_q   <= err_d;
                end
            end
        end
    end

    // Global advance: the pipe moves whenever the output slot is empty or being taken
    always_comb begin
        adv = !g_stage[STAGES-1].valid_q || bus.out_ready;
    end

    assign bus.in_ready   = adv;
    assign bus.out_valid  = g_stage[STAGES-1].valid_q;
    assign bus.out_result = g_stage[STAGES-1].value_q;
    assign bus.out_tag    = g_stage[STAGES-1].tag_q;
    assign bus.out_err    = g_stage[STAGES-1].err_q;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed self-checking bench for shift_unit_pipe.
// dut2 (STAGES=2) covers single ops, boundaries, tags, op 11 and backpressure;
// dut3 (STAGES=3) covers reset with a full pipe and a back-to-back run at full rate.
// Expected op-11 results depend on SHIFT_ROTATE_EN.
module tb_shift_unit_pipe;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    shift_if #(.WIDTH(64), .TAG_W(4)) bus2 ();
    shift_if #(.WIDTH(64), .TAG_W(4)) bus3 ();

    shift_unit_pipe #(.WIDTH(64), .STAGES(2), .TAG_W(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    shift_unit_pipe #(.WIDTH(64), .STAGES(3), .TAG_W(4)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    // Back-to-back vectors for dut3, expected values worked out by hand
    localparam int NV = 7;
    shift_op_e   vec_op [NV] = '{OP_SRL, OP_SLL, OP_SRA, OP_SRA, OP_SRL, OP_ROR, OP_SLL};
    logic [63:0] vec_a  [NV] = '{64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                 64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF,
                                 64'hFFFFFFFFFFFFFFFF};
    logic [5:0]  vec_sh [NV] = '{6'd4, 6'd12, 6'd8, 6'd62, 6'd33, 6'd8, 6'd1};
`ifdef SHIFT_ROTATE_EN
    logic [63:0] vec_exp[NV] = '{64'h00123456789ABCDE, 64'h3456789ABCDEF000, 64'hFFFEDCBA98765432,
                                 64'h0000000000000001, 64'h000000007FFFFFFF, 64'hEF0123456789ABCD,
                                 64'hFFFFFFFFFFFFFFFE};
    logic        vec_err[NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    logic [63:0] vec_exp[NV] = '{64'h00123456789ABCDE, 64'h3456789ABCDEF000, 64'hFFFEDCBA98765432,
                                 64'h0000000000000001, 64'h000000007FFFFFFF, 64'h000123456789ABCD,
                                 64'hFFFFFFFFFFFFFFFE};
    logic        vec_err[NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit to3, input shift_op_e op, input logic [63:0] a,
                                 input logic [5:0] sh, input logic [3:0] tag);
        if (to3) begin
            bus3.in_valid = 1'b1; bus3.in_op = op; bus3.in_a = a; bus3.in_shamt = sh; bus3.in_tag = tag;
        end else begin
            bus2.in_valid = 1'b1; bus2.in_op = op; bus2.in_a = a; bus2.in_shamt = sh; bus2.in_tag = tag;
        end
    endtask

    // One isolated op through dut2: accept, empty output after first edge, result after second
    task automatic runSingle(input string name, input shift_op_e op, input logic [63:0] a,
                             input logic [5:0] sh, input logic [3:0] tag,
                             input logic [63:0] exp_res, input logic exp_err);
        applyStimulus(1'b0, op, a, sh, tag);
        tick();
        bus2.in_valid = 1'b0;
        checkOutput({name, " early_valid"}, 64'(bus2.out_valid), 64'd0);
        tick();
        checkOutput({name, " valid"},  64'(bus2.out_valid), 64'd1);
        checkOutput({name, " result"}, bus2.out_result, exp_res);
        checkOutput({name, " tag"},    64'(bus2.out_tag), 64'(tag));
        checkOutput({name, " err"},    64'(bus2.out_err), 64'(exp_err));
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_op = OP_SLL; bus2.in_a = '0; bus2.in_shamt = '0; bus2.in_tag = '0;
        bus3.in_valid = 1'b0; bus3.in_op = OP_SLL; bus3.in_a = '0; bus3.in_shamt = '0; bus3.in_tag = '0;
        bus2.out_ready = 1'b1;
        bus3.out_ready = 1'b1;
        $display("[TB] start");
        tick();
        tick();
        rst = 1'b0;

        checkOutput("rst out_valid2",  64'(bus2.out_valid), 64'd0);
        checkOutput("rst out_result2", bus2.out_result, 64'd0);
        checkOutput("rst out_tag2",    64'(bus2.out_tag), 64'd0);
        checkOutput("rst out_err2",    64'(bus2.out_err), 64'd0);
        checkOutput("rst in_ready2",   64'(bus2.in_ready), 64'd1);
        checkOutput("rst out_valid3",  64'(bus3.out_valid), 64'd0);
        checkOutput("rst in_ready3",   64'(bus3.in_ready), 64'd1);

        runSingle("srl8",    OP_SRL, 64'hFF00000000000000, 6'd8,  4'h1, 64'h00FF000000000000, 1'b0);
        runSingle("srl0",    OP_SRL, 64'hFF00000000000000, 6'd0,  4'h2, 64'hFF00000000000000, 1'b0);
        runSingle("sra63",   OP_SRA, 64'h8000000000000000, 6'd63, 4'h3, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        runSingle("srl63",   OP_SRL, 64'h8000000000000000, 6'd63, 4'h4, 64'h0000000000000001, 1'b0);
        runSingle("sll63",   OP_SLL, 64'h0000000000000001, 6'd63, 4'hA, 64'h8000000000000000, 1'b0);
        runSingle("sll12",   OP_SLL, 64'h0123456789ABCDEF, 6'd12, 4'h5, 64'h3456789ABCDEF000, 1'b0);
        runSingle("sra_pos", OP_SRA, 64'h7000000000000000, 6'd4,  4'h6, 64'h0700000000000000, 1'b0);
        runSingle("sll0",    OP_SLL, 64'h0123456789ABCDEF, 6'd0,  4'h7, 64'h0123456789ABCDEF, 1'b0);
`ifdef SHIFT_ROTATE_EN
        runSingle("op11",    OP_ROR, 64'h0000000000000001, 6'd4,  4'hB, 64'h1000000000000000, 1'b0);
`else
        runSingle("op11",    OP_ROR, 64'h0000000000000001, 6'd4,  4'hB, 64'h0000000000000000, 1'b1);
`endif

        // Backpressure on dut2: two beats fill the pipe, the third waits for the stall to clear
        bus2.out_ready = 1'b0;
        applyStimulus(1'b0, OP_SRL, 64'h00000000000000F0, 6'd4, 4'h3);
        tick();
        applyStimulus(1'b0, OP_SLL, 64'h0000000000000001, 6'd1, 4'h4);
        tick();
        applyStimulus(1'b0, OP_SRA, 64'h8000000000000000, 6'd4, 4'h5);
        checkOutput("bp in_ready",  64'(bus2.in_ready), 64'd0);
        checkOutput("bp out_valid", 64'(bus2.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp hold ready",  64'(bus2.in_ready), 64'd0);
            checkOutput("bp hold result", bus2.out_result, 64'h000000000000000F);
            checkOutput("bp hold tag",    64'(bus2.out_tag), 64'd3);
        end
        bus2.out_ready = 1'b1;
        #1;
        checkOutput("bp release ready", 64'(bus2.in_ready), 64'd1);
        tick();
        bus2.in_valid = 1'b0;
        checkOutput("bp beat1 valid",  64'(bus2.out_valid), 64'd1);
        checkOutput("bp beat1 result", bus2.out_result, 64'h0000000000000002);
        checkOutput("bp beat1 tag",    64'(bus2.out_tag), 64'd4);
        tick();
        checkOutput("bp beat2 valid",  64'(bus2.out_valid), 64'd1);
        checkOutput("bp beat2 result", bus2.out_result, 64'hF800000000000000);
        checkOutput("bp beat2 tag",    64'(bus2.out_tag), 64'd5);
        tick();
        checkOutput("bp drained", 64'(bus2.out_valid), 64'd0);

        // Full-rate run through dut3: result i appears three edges after beat i is accepted
        for (int i = 0; i < NV + 2; i++) begin
            if (i < NV) begin
                applyStimulus(1'b1, vec_op[i], vec_a[i], vec_sh[i], 4'(i));
            end else begin
                bus3.in_valid = 1'b0;
            end
            tick();
            if (i >= 2) begin
                checkOutput("s3 valid",  64'(bus3.out_valid), 64'd1);
                checkOutput("s3 result", bus3.out_result, vec_exp[i-2]);
                checkOutput("s3 tag",    64'(bus3.out_tag), 64'(i - 2));
                checkOutput("s3 err",    64'(bus3.out_err), 64'(vec_err[i-2]));
            end else begin
                checkOutput("s3 early_valid", 64'(bus3.out_valid), 64'd0);
            end
        end
        tick();
        checkOutput("s3 drained", 64'(bus3.out_valid), 64'd0);

        // Reset with dut3 full: nothing in flight may ever reach the output
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, vec_op[i], vec_a[i], vec_sh[i], 4'(i + 8));
            tick();
        end
        bus3.in_valid = 1'b0;
        checkOutput("full valid",  64'(bus3.out_valid), 64'd1);
        checkOutput("full result", bus3.out_result, vec_exp[0]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst out_valid",  64'(bus3.out_valid), 64'd0);
        checkOutput("mid_rst in_ready",   64'(bus3.in_ready), 64'd1);
        checkOutput("mid_rst out_result", bus3.out_result, 64'd0);
        checkOutput("mid_rst out_tag",    64'(bus3.out_tag), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("post_rst quiet", 64'(bus3.out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
